// File: rtl/i2f_pkg.sv
// Shared types and constants for the integer-to-float converter arbiter.
package i2f_pkg;

  localparam int unsigned I2F_N_REQ_DEFAULT = 4;
  localparam int unsigned I2F_WIDTH         = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAccept  = 3'd1,
    StIssue   = 3'd2,
    StCollect = 3'd3,
    StDeliver = 3'd4
  } i2f_state_e;

endpackage

// File: rtl/i2f_arbiter_rr_pick.sv
// Combinational winner search over a request vector, starting at a rotating pointer.
// With I2F_ARB_FIXED_PRIO_EN defined the search always starts at index 0.
module rr_pick
  import i2f_pkg::*;
#(
  parameter int unsigned N_REQ = I2F_N_REQ_DEFAULT,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] start_eff;

`ifdef I2F_ARB_FIXED_PRIO_EN
  logic unused_start;
  assign unused_start = ^start;
  assign start_eff    = '0;
`else
  assign start_eff = start;
`endif

  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand     = (32'(start_eff) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/i2f_arbiter.sv
// Shares one integer-to-float converter among N_REQ requesters, one operation in flight.
// I2F_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module i2f_arbiter
  import i2f_pkg::*;
#(
  parameter int unsigned N_REQ = I2F_N_REQ_DEFAULT,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ*32-1:0]    req_a,
  input  logic [N_REQ-1:0]       req_a_stb,
  output logic [N_REQ-1:0]       req_a_ack,
  output logic [31:0]            resp_z,
  output logic [N_REQ-1:0]       resp_z_stb,
  input  logic [N_REQ-1:0]       resp_z_ack,
  output logic [31:0]            conv_a,
  output logic                   conv_a_stb,
  input  logic                   conv_a_ack,
  input  logic [31:0]            conv_z,
  input  logic                   conv_z_stb,
  output logic                   conv_z_ack,
  output logic [IDX_W-1:0]       grant_idx
);

  i2f_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] req_a_ack_q, req_a_ack_d;
  logic [31:0]      conv_a_q, conv_a_d;
  logic             conv_a_stb_q, conv_a_stb_d;
  logic             conv_z_ack_q, conv_z_ack_d;
  logic [31:0]      resp_z_q, resp_z_d;
  logic [N_REQ-1:0] resp_z_stb_q, resp_z_stb_d;
  logic [IDX_W-1:0] rr_start;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

`ifdef I2F_ARB_FIXED_PRIO_EN
  assign rr_start = '0;
`else
  logic [IDX_W-1:0] rr_q, rr_d;
  assign rr_start = rr_q;
`endif

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_pick (
    .req  (req_a_stb),
    .start(rr_start),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    req_a_ack_d  = req_a_ack_q;
    conv_a_d     = conv_a_q;
    conv_a_stb_d = conv_a_stb_q;
    conv_z_ack_d = conv_z_ack_q;
    resp_z_d     = resp_z_q;
    resp_z_stb_d = resp_z_stb_q;
`ifndef I2F_ARB_FIXED_PRIO_EN
    rr_d         = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d               = pick_idx;
          req_a_ack_d           = '0;
          req_a_ack_d[pick_idx] = 1'b1;
          state_d               = StAccept;
        end
      end
      StAccept: begin
        if (req_a_stb[grant_q] && req_a_ack_q[grant_q]) begin
          conv_a_d     = req_a[grant_q*I2F_WIDTH +: I2F_WIDTH];
          req_a_ack_d  = '0;
          conv_a_stb_d = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (conv_a_stb_q && conv_a_ack) begin
          conv_a_stb_d = 1'b0;
          conv_z_ack_d = 1'b1;
          state_d      = StCollect;
        end
      end
      StCollect: begin
        if (conv_z_stb && conv_z_ack_q) begin
          resp_z_d              = conv_z;
          conv_z_ack_d          = 1'b0;
          resp_z_stb_d          = '0;
          resp_z_stb_d[grant_q] = 1'b1;
          state_d               = StDeliver;
        end
      end
      StDeliver: begin
        // Pointer moves only once the result has actually been taken.
        if (resp_z_stb_q[grant_q] && resp_z_ack[grant_q]) begin
          resp_z_stb_d = '0;
`ifndef I2F_ARB_FIXED_PRIO_EN
          rr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      req_a_ack_q  <= '0;
      conv_a_q     <= '0;
      conv_a_stb_q <= 1'b0;
      conv_z_ack_q <= 1'b0;
      resp_z_q     <= '0;
      resp_z_stb_q <= '0;
`ifndef I2F_ARB_FIXED_PRIO_EN
      rr_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      req_a_ack_q  <= req_a_ack_d;
      conv_a_q     <= conv_a_d;
      conv_a_stb_q <= conv_a_stb_d;
      conv_z_ack_q <= conv_z_ack_d;
      resp_z_q     <= resp_z_d;
      resp_z_stb_q <= resp_z_stb_d;
`ifndef I2F_ARB_FIXED_PRIO_EN
      rr_q         <= rr_d;
`endif
    end
  end

  assign req_a_ack  = req_a_ack_q;
  assign resp_z     = resp_z_q;
  assign resp_z_stb = resp_z_stb_q;
  assign conv_a     = conv_a_q;
  assign conv_a_stb = conv_a_stb_q;
  assign conv_z_ack = conv_z_ack_q;
  assign grant_idx  = grant_q;

endmodule

// File: tb/tb_i2f_arbiter.sv
// Scoreboard bench for i2f_arbiter with a behavioural variable-latency converter.
module tb_i2f_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] req_a;
  logic [N-1:0]    req_a_stb, req_a_ack, resp_z_stb, resp_z_ack;
  logic [31:0]     resp_z, conv_a, conv_z;
  logic            conv_a_stb, conv_a_ack, conv_z_stb, conv_z_ack;
  logic [1:0]      grant_idx;

  i2f_arbiter #(
    .N_REQ(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_a_stb (req_a_stb),
    .req_a_ack (req_a_ack),
    .resp_z    (resp_z),
    .resp_z_stb(resp_z_stb),
    .resp_z_ack(resp_z_ack),
    .conv_a    (conv_a),
    .conv_a_stb(conv_a_stb),
    .conv_a_ack(conv_a_ack),
    .conv_z    (conv_z),
    .conv_z_stb(conv_z_stb),
    .conv_z_ack(conv_z_ack),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] z;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_deliv = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endfunction

  // Round-to-nearest-even int32 -> binary32, used only by the converter model.
  function automatic logic [31:0] i2f(input logic [31:0] a);
    logic        s;
    logic [31:0] m, mant, rem, half;
    int          p, e, sh;
    if (a == 32'd0) return 32'd0;
    s = a[31];
    m = s ? (~a + 32'd1) : a;
    p = 0;
    for (int k = 0; k < 32; k++) if (m[k]) p = k;
    e = 127 + p;
    if (p <= 23) begin
      mant = m << (23 - p);
    end else begin
      sh   = p - 23;
      mant = m >> sh;
      rem  = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        e    = e + 1;
      end
    end
    return {s, 8'(e), mant[22:0]};
  endfunction

  // Converter model: all activity 1 time unit after the falling edge.
  initial begin
    logic        a_x, z_x, rst_prev, busy;
    logic [31:0] op, op_seen;
    int          cnt;
    a_x = 0; z_x = 0; rst_prev = 1; busy = 0; op = 0; op_seen = 0; cnt = 0;
    conv_a_ack = 1'b1; conv_z_stb = 1'b0; conv_z = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_prev) begin
        conv_a_ack = 1'b1; conv_z_stb = 1'b0; busy = 0;
      end else begin
        if (a_x) begin
          conv_a_ack = 1'b0; op = op_seen; cnt = 5 + int'(op[2:0]); busy = 1;
        end
        if (z_x) begin
          conv_z_stb = 1'b0; conv_a_ack = 1'b1;
        end
        if (busy) begin
          if (cnt == 0) begin
            conv_z = i2f(op); conv_z_stb = 1'b1; busy = 0;
          end else cnt--;
        end
      end
      a_x      = !rst && conv_a_stb && conv_a_ack;
      op_seen  = conv_a;
      z_x      = !rst && conv_z_stb && conv_z_ack;
      rst_prev = rst;
    end
  end

  // Requesters drop stb once their operand has transferred.
  initial begin
    logic [N-1:0] clr;
    clr = '0;
    forever begin
      @(negedge clk); #1;
      req_a_stb = req_a_stb & ~clr;
      clr = rst ? '0 : (req_a_stb & req_a_ack);
    end
  end

  // Monitor: delivery scoreboard plus per-cycle handshake invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        check("ack_onehot", 32'($countones(req_a_ack) <= 1), 32'd1);
        check("ack_without_stb", {28'd0, req_a_ack & ~req_a_stb}, 32'd0);
        check("resp_stb_onehot", 32'($countones(resp_z_stb) <= 1), 32'd1);
        if (|(resp_z_stb & resp_z_ack)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_delivery", {28'd0, resp_z_stb}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_target", {28'd0, resp_z_stb}, 32'd1 << e.idx);
            check("resp_z", resp_z, e.z);
            check("grant_idx", {30'd0, grant_idx}, 32'(e.idx));
          end
          n_deliv++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input int i, input logic [31:0] d);
    req_a[i*32 +: 32] = d;
    req_a_stb[i]      = 1'b1;
  endtask

  task automatic expect_resp(input int i, input logic [31:0] z);
    exp_t e;
    e.idx = i; e.z = z;
    exp_q.push_back(e);
  endtask

  task automatic wait_deliv(input int target);
    int c = 0;
    while (n_deliv < target && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("delivery_count", 32'(n_deliv), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_a_ack"}, {28'd0, req_a_ack}, 32'd0);
    check({tag, "_resp_z_stb"}, {28'd0, resp_z_stb}, 32'd0);
    check({tag, "_conv_a_stb"}, {31'd0, conv_a_stb}, 32'd0);
    check({tag, "_conv_z_ack"}, {31'd0, conv_z_ack}, 32'd0);
    check({tag, "_conv_a"}, conv_a, 32'd0);
    check({tag, "_resp_z"}, resp_z, 32'd0);
    check({tag, "_grant_idx"}, {30'd0, grant_idx}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    #2;
    check_all_zero("post_reset");
    @(negedge clk);
  endtask

  initial begin
    int base, c;
    rst = 1'b1; req_a = '0; req_a_stb = '0; resp_z_ack = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check_all_zero("initial");

    // Single request from requester 1.
    @(negedge clk);
    expect_resp(1, 32'h3F800000);
    issue(1, 32'd1);
    wait_deliv(1);

    // All four together from a fresh pointer.
    do_reset();
    base = n_deliv;
    expect_resp(0, 32'h00000000);
    expect_resp(1, 32'hBF800000);
    expect_resp(2, 32'h40000000);
    expect_resp(3, 32'h4B800000);
    issue(0, 32'd0); issue(1, 32'hFFFFFFFF); issue(2, 32'd2); issue(3, 32'h01000001);
    wait_deliv(base + 4);

    // Requester 0 re-asserts after every delivery while requester 2 is pending.
    base = n_deliv;
`ifdef I2F_ARB_FIXED_PRIO_EN
    expect_resp(0, 32'h40A00000);
    expect_resp(0, 32'h42C80000);
    expect_resp(0, 32'h40800000);
    expect_resp(2, 32'h40E00000);
    issue(0, 32'd5); issue(2, 32'd7);
    wait_deliv(base + 1);
    issue(0, 32'd100);
    wait_deliv(base + 2);
    issue(0, 32'd4);
    wait_deliv(base + 4);
`else
    expect_resp(0, 32'h40A00000);
    expect_resp(2, 32'h40E00000);
    expect_resp(0, 32'h42C80000);
    expect_resp(2, 32'hC0000000);
    issue(0, 32'd5); issue(2, 32'd7);
    wait_deliv(base + 1);
    issue(0, 32'd100);
    wait_deliv(base + 2);
    issue(2, 32'hFFFFFFFE);
    wait_deliv(base + 4);
`endif

    // Backpressure on requester 3 with requester 0 waiting behind it.
    do_reset();
    base = n_deliv;
    resp_z_ack[3] = 1'b0;
    expect_resp(3, 32'h41200000);
    expect_resp(0, 32'h40400000);
    issue(3, 32'd10);
    repeat (3) @(negedge clk);
    issue(0, 32'd3);
    c = 0;
    while (!resp_z_stb[3] && c < 100) begin
      @(negedge clk); #2;
      c++;
    end
    check("bp_reached_deliver", {31'd0, resp_z_stb[3]}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      check("bp_resp_z_stb", {28'd0, resp_z_stb}, 32'h8);
      check("bp_resp_z", resp_z, 32'h41200000);
      check("bp_no_ack", {28'd0, req_a_ack}, 32'd0);
    end
    @(negedge clk);
    resp_z_ack[3] = 1'b1;
    wait_deliv(base + 2);

    // Reset while waiting on the converter; pointer is 1 here if not cleared.
    @(negedge clk);
    issue(1, 32'd6);
    c = 0;
    while (!conv_z_ack && c < 100) begin
      @(negedge clk); #2;
      c++;
    end
    check("reached_collect", {31'd0, conv_z_ack}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_all_zero("mid_reset");
    @(negedge clk);
    base = n_deliv;
    expect_resp(0, 32'h41000000);
    expect_resp(2, 32'h40400000);
    issue(2, 32'd3); issue(0, 32'd8);
    wait_deliv(base + 2);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
